key_evt_arbiter: RTL and testbench

- Collects debounced button levels from N debounce instances and turns each press into a one-byte event.
- Shares the single UART transmitter between the buttons with round-robin arbitration.
- Sits between the debounce bank and the UART TX byte interface.
- Pending events are queued one-deep per button; events that overflow are counted.

---
 rtl/key_evt_pkg.sv | 7 +
 rtl/rr_pick.sv | 17 +
 rtl/key_evt_arbiter.sv | 92 +++++++++
 tb/tb_key_evt_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_evt_pkg.sv
// key_evt_pkg: shared FSM state type and default event codes for key_evt_arbiter.
package key_evt_pkg;
  typedef enum logic {IDLE, REQ} state_t;
  localparam logic [7:0] PRESS_BASE_D = 8'h41;
  localparam logic [7:0] REL_BASE_D = 8'h61;
  localparam logic [7:0] DROP_MAX = 8'd255;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker, first set request at or after ptr.
module rr_pick #(
  parameter int M = 4,
  parameter int PW = $clog2(M)
) (
  input  logic [M-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [PW-1:0] gnt_idx,
  output logic          any
);
  always_comb begin
    gnt_idx = '0;
    any = |req;
    for (int k = M - 1; k >= 0; k--)
      if (req[(int'(ptr) + k) % M]) gnt_idx = PW'((int'(ptr) + k) % M);
  end
endmodule

// File: rtl/key_evt_arbiter.sv
// key_evt_arbiter: turns debounced key edges into UART event bytes with round-robin sharing.
// Define KEY_RELEASE_EN to also queue and send release events.
module key_evt_arbiter
  import key_evt_pkg::*;
#(
  parameter int         N_BTN      = 4,
  parameter logic [7:0] PRESS_BASE = PRESS_BASE_D,
  parameter logic [7:0] REL_BASE   = REL_BASE_D
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] key,
  input  logic             tx_ready,
  output logic             tx_valid,
  output logic [7:0]       tx_data,
  output logic [N_BTN-1:0] pend,
  output logic [7:0]       drop_cnt
);
`ifdef KEY_RELEASE_EN
  localparam int M = 2 * N_BTN;
`else
  localparam int M = N_BTN;
`endif
  localparam int PW = $clog2(M);
  state_t state, state_nx;
  logic [N_BTN-1:0] key_q, rise;
  logic armed, any, grant, accept, is_rel;
  logic [M-1:0] q, set_v, gnt_oh, drop_v;
  logic [PW-1:0] ptr, gnt_q, gnt_idx, btn;
  logic [4:0] n_drop;
  logic [8:0] drop_sum;

  // The arming edge only captures key, so keys held through reset stay silent.
  assign rise = armed ? key & ~key_q : '0;
`ifdef KEY_RELEASE_EN
  logic [N_BTN-1:0] fall;
  assign fall = armed ? ~key & key_q : '0;
  for (genvar i = 0; i < N_BTN; i++) begin : g_map
    assign set_v[2*i]   = rise[i];
    assign set_v[2*i+1] = fall[i];
    assign pend[i]      = q[2*i];
  end
  assign is_rel = gnt_idx[0];
  assign btn    = gnt_idx >> 1;
`else
  assign set_v  = rise;
  assign pend   = q;
  assign is_rel = 1'b0;
  assign btn    = gnt_idx;
`endif

  rr_pick #(.M(M)) u_pick (.req(q), .ptr(ptr), .gnt_idx(gnt_idx), .any(any));

  always_comb begin
    grant = state == IDLE && any;
    accept = state == REQ && tx_ready;
    state_nx = grant ? REQ : accept ? IDLE : state;
    gnt_oh = grant ? M'(1) << gnt_idx : '0;
    drop_v = set_v & q & ~gnt_oh;
    n_drop = 5'($countones(drop_v));
    drop_sum = {1'b0, drop_cnt} + 9'(n_drop);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      key_q <= '0;
      armed <= 1'b0;
      q <= '0;
      ptr <= '0;
      gnt_q <= '0;
      tx_valid <= 1'b0;
      tx_data <= '0;
      drop_cnt <= '0;
    end else begin
      state <= state_nx;
      key_q <= key;
      armed <= 1'b1;
      q <= (q & ~gnt_oh) | set_v;
      drop_cnt <= drop_sum > {1'b0, DROP_MAX} ? DROP_MAX : drop_sum[7:0];
      if (grant) begin
        tx_valid <= 1'b1;
        tx_data <= (is_rel ? REL_BASE : PRESS_BASE) + 8'(btn);
        gnt_q <= gnt_idx;
      end
      if (accept) begin
        tx_valid <= 1'b0;
        ptr <= gnt_q == PW'(M - 1) ? '0 : gnt_q + PW'(1);
      end
    end
  end
endmodule

// File: tb/tb_key_evt_arbiter.sv
// tb_key_evt_arbiter: directed and randomized checks against a queue-level reference model.
module tb_key_evt_arbiter;
  localparam int N = 4;
`ifdef KEY_RELEASE_EN
  localparam int M = 2 * N;
`else
  localparam int M = N;
`endif
  logic clk = 0, rst = 0, tx_ready = 0;
  logic [N-1:0] key = '0;
  logic tx_valid;
  logic [7:0] tx_data, drop_cnt;
  logic [N-1:0] pend;
  int total = 0, bad = 0;

  key_evt_arbiter #(.N_BTN(N)) dut (.clk(clk), .rst(rst), .key(key), .tx_ready(tx_ready),
    .tx_valid(tx_valid), .tx_data(tx_data), .pend(pend), .drop_cnt(drop_cnt));

  always #5 clk = ~clk;

  // Reference model: per-request pending flags, one busy slot, rotating pointer.
  logic [15:0] mq;
  logic [N-1:0] m_keyq;
  bit m_armed, m_busy;
  logic [7:0] m_data;
  int m_ptr, m_g, m_drop;
  logic [7:0] m_acc[$], d_acc[$];
  int d_time[$];
  int cyc = 0;

  function automatic logic [7:0] code(int j);
`ifdef KEY_RELEASE_EN
    return (j % 2) ? 8'(8'h61 + j / 2) : 8'(8'h41 + j / 2);
`else
    return 8'(8'h41 + j);
`endif
  endfunction

  function automatic logic [N-1:0] m_pend();
    logic [N-1:0] p;
    for (int i = 0; i < N; i++) p[i] = mq[i * M / N];
    return p;
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (rst && tx_valid && tx_ready) begin
      d_acc.push_back(tx_data);
      d_time.push_back(cyc);
    end
  end

  always @(posedge clk or negedge rst) begin
    logic [15:0] sv;
    int g;
    if (!rst) begin
      mq = 0; m_keyq = 0; m_armed = 0; m_busy = 0; m_data = 0;
      m_ptr = 0; m_g = 0; m_drop = 0;
    end else begin
      sv = 0;
      if (m_armed)
        for (int i = 0; i < N; i++) begin
          if (key[i] && !m_keyq[i]) sv[i * M / N] = 1;
`ifdef KEY_RELEASE_EN
          if (!key[i] && m_keyq[i]) sv[2 * i + 1] = 1;
`endif
        end
      g = -1;
      if (!m_busy)
        for (int k = 0; k < M; k++)
          if (g < 0 && mq[(m_ptr + k) % M]) g = (m_ptr + k) % M;
      for (int j = 0; j < M; j++)
        if (sv[j] && mq[j] && j != g) m_drop = m_drop < 255 ? m_drop + 1 : 255;
      if (g >= 0) mq[g] = 0;
      mq = mq | sv;
      if (m_busy && tx_ready) begin
        m_busy = 0;
        m_ptr = (m_g + 1) % M;
        m_acc.push_back(m_data);
      end else if (g >= 0) begin
        m_busy = 1;
        m_data = code(g);
        m_g = g;
      end
      m_keyq = key;
      m_armed = 1;
    end
  end

  task automatic drain();
    int n = 0;
    tx_ready = 1;
    do begin
      @(negedge clk);
      n++;
    end while ((m_busy || mq != 0 || tx_valid) && n < 200);
    total++;
    if (m_busy || mq != 0 || tx_valid) begin
      bad++;
      $display("FAIL drain timeout: tx_valid=%0b model_busy=%0b", tx_valid, m_busy);
    end
  endtask

  task automatic test_reset();
    key = 4'b0010;
    tx_ready = 1;
    #12;
    total += 4;
    if (tx_valid !== 1'b0) begin bad++; $display("FAIL reset tx_valid: got %0b want 0", tx_valid); end
    if (tx_data !== 8'h00) begin bad++; $display("FAIL reset tx_data: got %h want 00", tx_data); end
    if (pend !== '0) begin bad++; $display("FAIL reset pend: got %b want 0", pend); end
    if (drop_cnt !== 8'h00) begin bad++; $display("FAIL reset drop_cnt: got %0d want 0", drop_cnt); end
    @(negedge clk);
    rst = 1;
    repeat (20) begin
      @(negedge clk);
      total += 2;
      if (tx_valid !== 1'b0) begin bad++; $display("FAIL held_key tx_valid: got %0b want 0", tx_valid); end
      if (pend !== '0) begin bad++; $display("FAIL held_key pend: got %b want 0", pend); end
    end
    key = '0;
    drain();
  endtask

  task automatic test_single();
    int base;
    tx_ready = 0;
    key = 4'b0100;
    @(negedge clk);
    total += 2;
    if (pend !== 4'b0100) begin bad++; $display("FAIL single pend: got %b want 0100", pend); end
    if (tx_valid !== 1'b0) begin bad++; $display("FAIL single early valid: got %0b want 0", tx_valid); end
    base = d_acc.size();
    repeat (4) begin
      @(negedge clk);
      total += 2;
      if (tx_valid !== 1'b1) begin bad++; $display("FAIL single valid: got %0b want 1", tx_valid); end
      if (tx_data !== 8'h43) begin bad++; $display("FAIL single data: got %h want 43", tx_data); end
    end
    tx_ready = 1;
    @(negedge clk);
    total += 3;
    if (tx_valid !== 1'b0) begin bad++; $display("FAIL single after accept: got %0b want 0", tx_valid); end
    if (d_acc.size() - base !== 1) begin bad++; $display("FAIL single accepts: got %0d want 1", d_acc.size() - base); end
    else if (d_acc[base] !== 8'h43) begin bad++; $display("FAIL single byte: got %h want 43", d_acc[base]); end
    else total--;
    repeat (3) @(negedge clk);
    if (d_acc.size() - base !== 1) begin bad++; $display("FAIL single extra accept: got %0d want 1", d_acc.size() - base); end
    key = '0;
    drain();
  endtask

  task automatic collect(input int base, input int n);
    int t = 0;
    while (d_acc.size() - base < n && t < 100) begin
      @(negedge clk);
      t++;
    end
  endtask

  task automatic test_round_robin();
    int base;
    logic [7:0] exp1 [3];
    exp1 = '{8'h41, 8'h42, 8'h44};
    key = 4'b1000;
    drain();
    key = '0;
    drain();
    base = d_acc.size();
    key = 4'b1011;
    collect(base, 3);
    total++;
    if (d_acc.size() - base < 3) begin bad++; $display("FAIL rr count: got %0d want 3", d_acc.size() - base); end
    else begin
      for (int i = 0; i < 3; i++) begin
        total++;
        if (d_acc[base + i] !== exp1[i]) begin bad++; $display("FAIL rr byte%0d: got %h want %h", i, d_acc[base + i], exp1[i]); end
      end
      for (int i = 1; i < 3; i++) begin
        total++;
        if (d_time[base + i] - d_time[base + i - 1] !== 2) begin
          bad++; $display("FAIL rr gap%0d: got %0d want 2", i, d_time[base + i] - d_time[base + i - 1]);
        end
      end
    end
    key = '0;
    drain();
    base = d_acc.size();
    key = 4'b0011;
    collect(base, 2);
    total++;
    if (d_acc.size() - base < 2) begin bad++; $display("FAIL rr wrap count: got %0d want 2", d_acc.size() - base); end
    else if (d_acc[base] !== 8'h41 || d_acc[base + 1] !== 8'h42)
      begin bad++; $display("FAIL rr wrap order: got %h %h want 41 42", d_acc[base], d_acc[base + 1]); end
    key = '0;
    drain();
  endtask

  task automatic test_coalesce();
    int base, d0, n42;
    logic [N-1:0] seq [6];
    seq = '{4'b1000, 4'b1010, 4'b1000, 4'b1010, 4'b1000, 4'b1010};
    tx_ready = 0;
    d0 = m_drop;
    foreach (seq[i]) begin
      key = seq[i];
      @(negedge clk);
      if (i == 0) @(negedge clk);
    end
    @(negedge clk);
    total += 2;
    if (pend[1] !== 1'b1) begin bad++; $display("FAIL coalesce pend1: got %b want 1", pend[1]); end
`ifdef KEY_RELEASE_EN
    if (drop_cnt !== 8'(d0 + 3)) begin bad++; $display("FAIL coalesce drops: got %0d want %0d", drop_cnt, d0 + 3); end
`else
    if (drop_cnt !== 8'(d0 + 2)) begin bad++; $display("FAIL coalesce drops: got %0d want %0d", drop_cnt, d0 + 2); end
`endif
    for (int i = 0; i < 300; i++) begin
      key[1] = 1'b0;
      @(negedge clk);
      key[1] = 1'b1;
      @(negedge clk);
    end
    total++;
    if (drop_cnt !== 8'd255) begin bad++; $display("FAIL drop saturate: got %0d want 255", drop_cnt); end
    base = d_acc.size();
    tx_ready = 1;
    repeat (10) @(negedge clk);
    n42 = 0;
    for (int i = base; i < d_acc.size(); i++) if (d_acc[i] == 8'h42) n42++;
    total++;
    if (n42 !== 1) begin bad++; $display("FAIL coalesce sends: got %0d want 1", n42); end
    tx_ready = 0;
    key[1] = 1'b0;
    repeat (2) @(negedge clk);
    key[1] = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int base;
    total++;
    if (tx_valid !== 1'b1) begin bad++; $display("FAIL mid setup valid: got %0b want 1", tx_valid); end
    #2 rst = 0;
    #1;
    total += 3;
    if (tx_valid !== 1'b0) begin bad++; $display("FAIL mid reset valid: got %0b want 0", tx_valid); end
    if (pend !== '0) begin bad++; $display("FAIL mid reset pend: got %b want 0", pend); end
    if (drop_cnt !== 8'h00) begin bad++; $display("FAIL mid reset drop: got %0d want 0", drop_cnt); end
    key = '0;
    tx_ready = 1;
    @(negedge clk);
    rst = 1;
    base = d_acc.size();
    repeat (20) @(negedge clk);
    total++;
    if (d_acc.size() !== base || tx_valid !== 1'b0)
      begin bad++; $display("FAIL mid spurious: got %0d bytes want 0", d_acc.size() - base); end
  endtask

  task automatic test_random();
    m_acc.delete();
    d_acc.delete();
    d_time.delete();
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      total += 3;
      if (tx_valid !== m_busy) begin bad++; $display("FAIL rand valid c%0d: got %0b want %0b", c, tx_valid, m_busy); end
      if (pend !== m_pend()) begin bad++; $display("FAIL rand pend c%0d: got %b want %b", c, pend, m_pend()); end
      if (drop_cnt !== 8'(m_drop)) begin bad++; $display("FAIL rand drop c%0d: got %0d want %0d", c, drop_cnt, m_drop); end
      if (m_busy) begin
        total++;
        if (tx_data !== m_data) begin bad++; $display("FAIL rand data c%0d: got %h want %h", c, tx_data, m_data); end
      end
      for (int i = 0; i < N; i++) if ($urandom_range(0, 5) == 0) key[i] = ~key[i];
      tx_ready = $urandom_range(0, 2) != 0;
    end
    key = '0;
    drain();
    total++;
    if (d_acc != m_acc) begin bad++; $display("FAIL rand stream: got %0d bytes want %0d", d_acc.size(), m_acc.size()); end
  endtask

`ifdef KEY_RELEASE_EN
  task automatic test_release();
    int base;
    key = 4'b0001;
    drain();
    base = d_acc.size();
    key = '0;
    collect(base, 1);
    total++;
    if (d_acc.size() <= base || d_acc[base] !== 8'h61) begin bad++; $display("FAIL release byte: want 61"); end
    drain();
    tx_ready = 0;
    key = 4'b1000;
    repeat (3) @(negedge clk);
    key = 4'b1001;
    @(negedge clk);
    key = 4'b1000;
    @(negedge clk);
    base = d_acc.size();
    tx_ready = 1;
    collect(base, 3);
    total++;
    if (d_acc.size() - base < 3 || d_acc[base + 1] !== 8'h41 || d_acc[base + 2] !== 8'h61)
      begin bad++; $display("FAIL release order: want 44 41 61"); end
    key = '0;
    drain();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_coalesce();
    test_reset_mid();
`ifdef KEY_RELEASE_EN
    test_release();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
